// File: rtl/vigna_pkg.sv
// Shared types and constants for the vigna bus arbiter.
package vigna_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna instruction and data ports onto one shared memory bus.
// Define VIGNA_ARB_ROUND_ROBIN_EN to alternate on contention instead of data-first priority.
module vigna_bus_arbiter
    import vigna_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,

    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb
);

    arb_state_t state_reg, state_next;
    logic       pick_d;

    // Read data is broadcast; each requester qualifies it with its own ready.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

`ifdef VIGNA_ARB_ROUND_ROBIN_EN
    logic last_grant_reg, last_grant_next;

    assign pick_d = d_valid && (!i_valid || (last_grant_reg == GNT_I));

    always_comb begin
        last_grant_next = last_grant_reg;
        if (m_ready && (state_reg == ARB_I)) last_grant_next = GNT_I;
        if (m_ready && (state_reg == ARB_D)) last_grant_next = GNT_D;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_grant_reg <= GNT_I;
        else         last_grant_reg <= last_grant_next;
    end
`else
    assign pick_d = d_valid;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= ARB_IDLE;
        else         state_reg <= state_next;
    end

    // Grant is held until m_ready; every transfer returns through ARB_IDLE so
    // the just-served requester's valid is never seen stale on the bus.
    always_comb begin
        state_next = state_reg;
        m_valid    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_wstrb    = '0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (i_valid || d_valid) state_next = pick_d ? ARB_D : ARB_I;
            end
            ARB_I: begin
                m_valid = i_valid;
                m_addr  = i_addr;
                m_wdata = i_wdata;
                m_wstrb = i_wstrb;
                i_ready = m_ready;
                if (m_ready) state_next = ARB_IDLE;
            end
            ARB_D: begin
                m_valid = d_valid;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
                d_ready = m_ready;
                if (m_ready) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Self-checking bench for vigna_bus_arbiter: directed scenarios then randomized traffic
// against a transaction-level reference model of who owns the bus.
module tb_vigna_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_valid, i_ready, d_valid, d_ready, m_valid, m_ready;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] i_rdata, i_wdata, d_rdata, d_wdata, m_rdata, m_wdata;
    logic [SW-1:0] i_wstrb, d_wstrb, m_wstrb;

    vigna_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner 0 = nobody, 1 = instruction port, 2 = data port.
    int owner;
    bit last_d;
    bit i_act, d_act, i_drop, d_drop;

    logic [AW-1:0] dir_i_addr, dir_d_addr;
    logic [DW-1:0] dir_d_wdata, dir_rdata;
    logic [SW-1:0] dir_d_wstrb;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Who wins when the bus is free.
    function automatic int arbitrate(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
            return last_d ? 1 : 2;
`else
            return 2;
`endif
        end
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    task automatic run_cycle(input bit rnd, input bit want_i, input bit want_d, input bit mr);
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [SW-1:0] e_wstrb;
        bit            e_valid;
        @(posedge clk);
        #1;
        if (i_drop) begin
            i_act  = 1'b0;
            i_drop = 1'b0;
        end else if (!i_act && (rnd ? ($urandom_range(0, 2) == 0) : want_i)) begin
            i_act   = 1'b1;
            i_addr  = rnd ? $urandom : dir_i_addr;
            i_wdata = rnd ? $urandom : '0;
            i_wstrb = rnd ? SW'($urandom) : '0;
        end
        if (!i_act) begin
            i_addr  = $urandom;
            i_wdata = $urandom;
            i_wstrb = SW'($urandom);
        end
        if (d_drop) begin
            d_act  = 1'b0;
            d_drop = 1'b0;
        end else if (!d_act && (rnd ? ($urandom_range(0, 2) == 0) : want_d)) begin
            d_act   = 1'b1;
            d_addr  = rnd ? $urandom : dir_d_addr;
            d_wdata = rnd ? $urandom : dir_d_wdata;
            d_wstrb = rnd ? SW'($urandom) : dir_d_wstrb;
        end
        if (!d_act) begin
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = SW'($urandom);
        end
        i_valid = i_act;
        d_valid = d_act;
        #1;
        if (rnd) m_ready = m_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        else     m_ready = mr;
        m_rdata = rnd ? $urandom : dir_rdata;
        #1;

        e_valid = (owner == 1) ? i_act : (owner == 2) ? d_act : 1'b0;
        e_addr  = (owner == 1) ? i_addr  : (owner == 2) ? d_addr  : '0;
        e_wdata = (owner == 1) ? i_wdata : (owner == 2) ? d_wdata : '0;
        e_wstrb = (owner == 1) ? i_wstrb : (owner == 2) ? d_wstrb : '0;
        check_eq("m_valid", 64'(m_valid), 64'(e_valid));
        check_eq("m_addr",  64'(m_addr),  64'(e_addr));
        check_eq("m_wdata", 64'(m_wdata), 64'(e_wdata));
        check_eq("m_wstrb", 64'(m_wstrb), 64'(e_wstrb));
        check_eq("i_ready", 64'(i_ready), 64'((owner == 1) && m_ready));
        check_eq("d_ready", 64'(d_ready), 64'((owner == 2) && m_ready));
        check_eq("i_rdata", 64'(i_rdata), 64'(m_rdata));
        check_eq("d_rdata", 64'(d_rdata), 64'(m_rdata));

        if (owner == 0) begin
            owner = arbitrate(i_act, d_act);
        end else if (m_ready) begin
            $display("[TB] xfer port=%s addr=%08h wstrb=%h rdata=%08h",
                     (owner == 1) ? "I" : "D", e_addr, e_wstrb, m_rdata);
            if (owner == 1) i_drop = 1'b1;
            else            d_drop = 1'b1;
            last_d = (owner == 2);
            owner  = 0;
        end
    endtask

    initial begin
        resetn  = 1'b0;
        i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_wstrb = '0;
        d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        m_ready = 1'b0; m_rdata = '0;
        owner = 0; last_d = 1'b0;
        i_act = 1'b0; d_act = 1'b0; i_drop = 1'b0; d_drop = 1'b0;
        dir_i_addr = '0; dir_d_addr = '0; dir_d_wdata = '0; dir_d_wstrb = '0; dir_rdata = '0;

        #12;
        check_eq("rst_m_valid", 64'(m_valid), 64'(0));
        check_eq("rst_i_ready", 64'(i_ready), 64'(0));
        check_eq("rst_d_ready", 64'(d_ready), 64'(0));
        check_eq("rst_m_addr",  64'(m_addr),  64'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Instruction fetch from address 0
        dir_i_addr = 32'h0000_0000;
        dir_rdata  = 32'h0000_0013;
        run_cycle(0, 1, 0, 0);
        check_eq("t1_arb_cycle_m_valid", 64'(m_valid), 64'(0));
        run_cycle(0, 0, 0, 1);
        check_eq("t1_m_valid", 64'(m_valid), 64'(1));
        check_eq("t1_m_addr",  64'(m_addr),  64'(0));
        check_eq("t1_i_ready", 64'(i_ready), 64'(1));
        check_eq("t1_i_rdata", 64'(i_rdata), 64'(32'h13));
        check_eq("t1_d_ready", 64'(d_ready), 64'(0));
        run_cycle(0, 0, 0, 0);

        // Store
        dir_d_addr  = 32'h0000_0100;
        dir_d_wdata = 32'hDEAD_BEEF;
        dir_d_wstrb = 4'hF;
        dir_rdata   = 32'h0;
        run_cycle(0, 0, 1, 0);
        run_cycle(0, 0, 0, 1);
        check_eq("t2_m_wdata", 64'(m_wdata), 64'(32'hDEAD_BEEF));
        check_eq("t2_m_wstrb", 64'(m_wstrb), 64'(4'hF));
        check_eq("t2_d_ready", 64'(d_ready), 64'(1));
        run_cycle(0, 0, 0, 0);
        check_eq("t2_bubble_m_valid", 64'(m_valid), 64'(0));
        check_eq("t2_bubble_d_ready", 64'(d_ready), 64'(0));

        // Simultaneous requests
        dir_i_addr  = 32'h0000_0200;
        dir_d_addr  = 32'h0000_0300;
        dir_d_wstrb = 4'h0;
        dir_rdata   = 32'h1234_5678;
        run_cycle(0, 1, 1, 0);
        run_cycle(0, 0, 0, 1);
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
        check_eq("t3_first_addr",    64'(m_addr),  64'(32'h200));
        check_eq("t3_first_i_ready", 64'(i_ready), 64'(1));
`else
        check_eq("t3_first_addr",    64'(m_addr),  64'(32'h300));
        check_eq("t3_first_d_ready", 64'(d_ready), 64'(1));
`endif
        run_cycle(0, 0, 0, 0);
        check_eq("t3_bubble_m_valid", 64'(m_valid), 64'(0));
        run_cycle(0, 0, 0, 1);
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
        check_eq("t3_second_addr", 64'(m_addr), 64'(32'h300));
`else
        check_eq("t3_second_addr", 64'(m_addr), 64'(32'h200));
`endif
        run_cycle(0, 0, 0, 0);

        // Grant hold with a late memory reply while d arrives
        dir_i_addr = 32'h0000_0400;
        dir_d_addr = 32'h0000_0500;
        run_cycle(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            run_cycle(0, 0, (k == 1), 0);
            check_eq("t4_hold_addr",    64'(m_addr),  64'(32'h400));
            check_eq("t4_hold_d_ready", 64'(d_ready), 64'(0));
        end
        run_cycle(0, 0, 0, 1);
        check_eq("t4_i_ready", 64'(i_ready), 64'(1));
        run_cycle(0, 0, 0, 0);
        run_cycle(0, 0, 0, 1);
        check_eq("t4_d_addr",  64'(m_addr),  64'(32'h500));
        check_eq("t4_d_ready", 64'(d_ready), 64'(1));
        run_cycle(0, 0, 0, 0);

        // Stray m_ready while idle
        run_cycle(0, 0, 0, 1);
        check_eq("t5_stray_i_ready", 64'(i_ready), 64'(0));
        check_eq("t5_stray_d_ready", 64'(d_ready), 64'(0));
        run_cycle(0, 0, 0, 1);
        dir_i_addr = 32'h0000_0600;
        run_cycle(0, 1, 0, 0);
        run_cycle(0, 0, 0, 0);
        check_eq("t5_after_stray_m_valid", 64'(m_valid), 64'(1));
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 0);

        // Asynchronous reset in the middle of a data grant
        dir_d_addr = 32'h0000_0700;
        run_cycle(0, 0, 1, 0);
        run_cycle(0, 0, 0, 0);
        m_ready = 1'b1;
        #1;
        check_eq("t6_pre_d_ready", 64'(d_ready), 64'(1));
        resetn = 1'b0;
        #1;
        check_eq("t6_async_m_valid", 64'(m_valid), 64'(0));
        check_eq("t6_async_d_ready", 64'(d_ready), 64'(0));
        check_eq("t6_async_m_addr",  64'(m_addr),  64'(0));
        m_ready = 1'b0;
        d_valid = 1'b0;
        i_valid = 1'b0;
        owner = 0; last_d = 1'b0;
        i_act = 1'b0; d_act = 1'b0; i_drop = 1'b0; d_drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        dir_i_addr = 32'h0000_0800;
        run_cycle(0, 1, 0, 0);
        run_cycle(0, 0, 0, 1);
        check_eq("t6_fresh_m_addr",  64'(m_addr),  64'(32'h800));
        check_eq("t6_fresh_i_ready", 64'(i_ready), 64'(1));
        run_cycle(0, 0, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) run_cycle(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
